// File: rtl/shll_seq.sv
// ---------------------------------------------------------------------------
// shll_seq -- multi-cycle 32-bit logical left shifter
//
// Shifts a captured operand left by a captured amount, at most STEP bits per
// clock. Amounts of 32 or more give zero. One operation at a time; start is
// ignored while an operation is in flight.
//
// Parameters
//   STEP     maximum bits shifted per SHIFT cycle (1, 2, 4 or 8)
//
// Ports
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   start    request a new shift (sampled only when idle)
//   input1   operand, captured when start is accepted
//   shift    unsigned shift amount, captured when start is accepted
//   shifted  registered result; updates only when an operation completes
//   busy     high whenever an operation is in flight (SHIFT or DONE)
//   done     one-cycle pulse marking a new result on shifted
// ---------------------------------------------------------------------------
module shll_seq #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] input1,
    input  logic [31:0] shift,
    output logic [31:0] shifted,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [5:0] STEP_W = 6'(STEP);

    logic [1:0]  state_q,   state_d;
    logic [31:0] acc_q,     acc_d;
    logic [5:0]  rem_q,     rem_d;
    logic [31:0] shifted_q, shifted_d;

    logic [5:0]  eff;
    logic [5:0]  step_amt;

    // Any set bit above bit 4 means the amount is at least 32; saturate to 32
    // so the operand is fully shifted out.
    always_comb begin
        eff = (|shift[31:5]) ? 6'd32 : {1'b0, shift[4:0]};
    end

    always_comb begin
        step_amt = (rem_q < STEP_W) ? rem_q : STEP_W;
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        shifted_d = shifted_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d = input1;
                    rem_d = eff;
                    if (eff == 6'd0) begin
                        // Zero-length shift completes immediately with the operand.
                        state_d   = S_DONE;
                        shifted_d = input1;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = acc_q << step_amt;
                rem_d = rem_q - step_amt;
                if (rem_d == 6'd0) begin
                    state_d   = S_DONE;
                    shifted_d = acc_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            rem_q     <= '0;
            shifted_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            shifted_q <= shifted_d;
        end
    end

    assign shifted = shifted_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_shll_seq.sv
// ---------------------------------------------------------------------------
// tb_shll_seq -- self-checking bench for shll_seq
//
// Two instances (STEP=1 and STEP=4) share clock and inputs. A reference model
// tracks, per instance, the expected result (plain << with saturation) and
// the number of busy cycles still owed (ceil(eff/STEP)+1), and every cycle the
// DUT outputs are compared against it on the falling edge.
// ---------------------------------------------------------------------------
module tb_shll_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] input1;
    logic [31:0] shift;

    logic [31:0] shifted_o [2];
    logic        busy_o    [2];
    logic        done_o    [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    shll_seq #(.STEP(1)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .input1  (input1),
        .shift   (shift),
        .shifted (shifted_o[0]),
        .busy    (busy_o[0]),
        .done    (done_o[0])
    );

    shll_seq #(.STEP(4)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .input1  (input1),
        .shift   (shift),
        .shifted (shifted_o[1]),
        .busy    (busy_o[1]),
        .done    (done_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int step_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int eff_of(input logic [31:0] sh);
        return (sh >= 32) ? 32 : int'(sh);
    endfunction

    function automatic logic [31:0] res_of(input logic [31:0] a, input logic [31:0] sh);
        int e;
        e = eff_of(sh);
        if (e >= 32) return 32'h0;
        return a << e;
    endfunction

    function automatic int lat_of(input logic [31:0] sh, input int step);
        return (eff_of(sh) + step - 1) / step + 1;
    endfunction

    int          m_cnt  [2] = '{0, 0};   // busy cycles remaining, done when 1
    logic [31:0] m_pend [2];
    logic [31:0] m_shd  [2] = '{32'h0, 32'h0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cnt[i] <= 0;
                m_shd[i] <= 32'h0;
            end else if (m_cnt[i] == 0) begin
                if (start) begin
                    m_cnt[i]  <= lat_of(shift, step_of(i));
                    m_pend[i] <= res_of(input1, shift);
                    if (lat_of(shift, step_of(i)) == 1)
                        m_shd[i] <= res_of(input1, shift);
                end
            end else begin
                m_cnt[i] <= m_cnt[i] - 1;
                if (m_cnt[i] == 2)
                    m_shd[i] <= m_pend[i];
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy_s1",    32'(busy_o[0]), 32'(m_cnt[0] > 0));
            check("done_s1",    32'(done_o[0]), 32'(m_cnt[0] == 1));
            check("shifted_s1", shifted_o[0],   m_shd[0]);
            check("busy_s4",    32'(busy_o[1]), 32'(m_cnt[1] > 0));
            check("done_s4",    32'(done_o[1]), 32'(m_cnt[1] == 1));
            check("shifted_s4", shifted_o[1],   m_shd[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        for (int c = 0; c < 100 && (busy_o[0] || busy_o[1]); c++)
            @(negedge clk);
        check("idle_timeout", {30'h0, busy_o[1], busy_o[0]}, 32'h0);
    endtask

    // Pulse start for one cycle, scramble inputs afterwards, then wait for
    // both instances to return to idle.
    task automatic op(input logic [31:0] a, input logic [31:0] sh);
        start  = 1'b1;
        input1 = a;
        shift  = sh;
        @(negedge clk);
        start  = 1'b0;
        input1 = $urandom;
        shift  = $urandom;
        wait_idle();
    endtask

    function automatic logic [31:0] rand_shift();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return $urandom;
        if (r == 1) return 32'd32;
        return 32'($urandom_range(0, 33));
    endfunction

    int cyc;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        input1 = '0;
        shift  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        check("rst_shifted", shifted_o[0] | shifted_o[1], 32'h0);
        rst = 1'b0;

        // Directed: 1<<4 on STEP=1 -> done exactly in cycle 5
        start = 1'b1; input1 = 32'h1; shift = 32'd4;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done_o[0] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("lat_1sh4", 32'(cyc), 32'd5);
        check("res_1sh4", shifted_o[0], 32'h10);
        wait_idle();

        op(32'hDEADBEEF, 32'd0);
        check("res_sh0", shifted_o[1], 32'hDEADBEEF);
        op(32'hFFFFFFFF, 32'h20);
        check("res_sh32", shifted_o[0], 32'h0);
        op(32'hFFFFFFFF, 32'h80000003);
        check("res_shbig", shifted_o[0], 32'h0);
        op(32'h12345678, 32'd9);
        check("res_s4", shifted_o[1], 32'h68ACF000);

        // start held high with inputs changing every cycle
        start = 1'b1;
        for (int k = 0; k < 300; k++) begin
            input1 = $urandom;
            shift  = rand_shift();
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        // Reset in third SHIFT cycle of a shift=10 operation
        start = 1'b1; input1 = 32'hCAFEF00D; shift = 32'd10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_abort_busy", {30'h0, busy_o[1], busy_o[0]}, 32'h0);
        check("rst_abort_shd", shifted_o[0], 32'h0);
        op(32'h3, 32'd1);
        check("after_rst", shifted_o[0], 32'h6);

        // Random single operations
        for (int k = 0; k < 40; k++)
            op($urandom, rand_shift());

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shll_seq.md
SHLL_SEQ -- requirements
Module: shll_seq

Interface
REQ-001 The block SHALL have parameter STEP, default 1, giving the maximum bits shifted per SHIFT cycle; legal values are 1, 2, 4 and 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new shift; sampled only in IDLE.
REQ-005 The block SHALL have port input1, input, 32 bits: the operand, captured when start is accepted.
REQ-006 The block SHALL have port shift, input, 32 bits: the unsigned shift amount, captured when start is accepted.
REQ-007 The block SHALL have port shifted, output, 32 bits: the registered logical-left-shift result.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid new result on shifted.

Function
REQ-010 The block SHALL compute shifted = input1 << shift (logical, zero fill) over 32 bits, matching the single-cycle right-shift unit's semantics mirrored.
REQ-011 The effective amount SHALL be eff = 32 if shift[31:5] != 0, else shift[4:0]; any amount of 32 or more yields 0x00000000.
REQ-012 The state machine SHALL have states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1 at a clock edge, the block SHALL load acc=input1 and rem=eff, then go to DONE if eff=0, else to SHIFT.
REQ-014 In IDLE with start=0, the block SHALL hold all state.
REQ-015 In SHIFT, each edge SHALL do acc <= acc << min(STEP, rem) and rem <= rem - min(STEP, rem); the block SHALL go to DONE when the updated rem is 0.
REQ-016 On entry to DONE, shifted SHALL be loaded with the final acc; for eff=0 the loaded value is input1 unchanged.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL go unconditionally to IDLE.
REQ-018 Latency SHALL be: start sampled at edge 0, done high in cycle ceil(eff/STEP)+1, which is cycle 1 when eff=0.
REQ-019 With STEP=1 the worst case SHALL be done in cycle 33.
REQ-020 start SHALL be ignored while busy=1, including in DONE; changes to input1 or shift after capture SHALL NOT affect the result.
REQ-021 start may be asserted in the first IDLE cycle after DONE; back-to-back operations SHALL therefore have a minimum spacing of ceil(eff/STEP)+2 cycles.
REQ-022 shifted SHALL hold its last value outside DONE entry and change only on DONE entry.

Reset
REQ-023 With rst=1 at an edge, the block SHALL set state=IDLE, acc=0, rem=0, shifted=0x00000000, busy=0 and done=0.
REQ-024 rst SHALL take priority over start and over any state.
REQ-025 Reset mid-SHIFT SHALL abort the operation with no done pulse, and shifted SHALL read 0.
REQ-026 In the cycle after rst deasserts, the block SHALL accept start normally.

Verification
REQ-027 With STEP=1, input1=0x00000001, shift=4, start for 1 cycle -> busy in cycles 1-5, done only in cycle 5, shifted=0x00000010.
REQ-028 With input1=0xDEADBEEF, shift=0 -> done in cycle 1, shifted=0xDEADBEEF, busy high only in cycle 1.
REQ-029 With input1=0xFFFFFFFF, shift=0x00000020, then shift=0x80000003 -> both give shifted=0x00000000; with STEP=1 done in cycle 33 each.
REQ-030 With STEP=4, input1=0x12345678, shift=9 -> done in cycle 4, shifted=0x68ACF000.
REQ-031 start held high continuously, and input1/shift changed during busy -> exactly one result per operation, equal to the captured operands, with a new operation accepted in the cycle after each DONE.
REQ-032 rst asserted in the third SHIFT cycle of a shift=10 operation -> no done, shifted=0, busy=0 next cycle; then input1=0x3, shift=1 -> shifted=0x00000006.
